// File: rtl/dotp_pkg.sv
// ----------------------------------------------------------------------------
// dotp_pkg
// Shared definitions for the dot-product controller slice.
//  - Default widths and limits used as parameter defaults by the modules.
//  - dotp_state_t: controller state encoding
//    (LOAD -> FLUSH -> KICK -> ACCUM -> RESULT).
//  - acc_width(): accumulator width that cannot overflow for a full job.
// No ports (package).
// ----------------------------------------------------------------------------
package dotp_pkg;

   localparam int DEFAULT_DATA_WIDTH     = 8;
   localparam int DEFAULT_VECTOR_WIDTH   = 4;
   localparam int DEFAULT_ADDR_WIDTH     = 5;
   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

   typedef enum logic [2:0] {
      ST_LOAD   = 3'd0,
      ST_FLUSH  = 3'd1,
      ST_KICK   = 3'd2,
      ST_ACCUM  = 3'd3,
      ST_RESULT = 3'd4
   } dotp_state_t;

   // Each product needs 2*data_width bits, and summing vector_width of them
   // needs clog2(vector_width) extra bits of headroom.
   function automatic int acc_width(input int data_width, input int vector_width);
      return 2 * data_width + $clog2(vector_width);
   endfunction

endpackage

// File: rtl/dotp_mac.sv
// ----------------------------------------------------------------------------
// dotp_mac
// Multiply-accumulate register: acc <= acc + a*b when enabled.
// Ports:
//  clk     in   clock, rising edge
//  rst     in   synchronous active-high reset, clears acc
//  clear   in   synchronous clear of acc (has priority over enable)
//  enable  in   add a*b to acc this cycle
//  a, b    in   DATA_WIDTH unsigned operands
//  acc     out  ACC_WIDTH accumulator
// ----------------------------------------------------------------------------
module dotp_mac
   import dotp_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ACC_WIDTH  = acc_width(DEFAULT_DATA_WIDTH, DEFAULT_VECTOR_WIDTH)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  acc
);

   logic [2*DATA_WIDTH-1:0] product;

   // Full-width unsigned product; operands are widened explicitly so the
   // multiply is evaluated at 2*DATA_WIDTH bits.
   assign product = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

   // The cast zero-extends the product when the accumulator is wider, and
   // truncates it (giving modulo-2^ACC_WIDTH wrap) when it is narrower.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc + ACC_WIDTH'(product);
      end
   end

endmodule

// File: rtl/dot_product_controller.sv
// ----------------------------------------------------------------------------
// dot_product_controller
// Sequences one dot-product job through input_memory_wrapper: loads
// VECTOR_WIDTH (a,b) pairs into addresses 0..VECTOR_WIDTH-1, kicks the
// wrapper's reader, accumulates a*b per data_valid beat and presents the sum
// on a valid/ready result port. One job in flight at a time.
//
// Optional feature macro: DOTP_TIMEOUT_EN
//  When defined, a watchdog aborts ACCUM after TIMEOUT_CYCLES cycles without
//  reading_done, sets the sticky error flag and returns to LOAD.
//  When undefined, ACCUM waits indefinitely and error is tied to 0.
//
// Ports:
//  clk, rst                      clock / synchronous active-high reset
//  in_valid, in_ready            upstream element-pair handshake
//  in_a, in_b                    element pair
//  write_en, write_addr,
//  data_a, data_b                write port toward the wrapper
//  start_reading                 one-cycle read kick toward the wrapper
//  reading_done, data_valid,
//  mem1_output, mem2_output      read stream from the wrapper
//  element_count                 wrapper status, informational only
//  out_valid, out_ready,
//  out_result                    result handshake and dot product
//  busy                          high whenever not in LOAD
//  error                         sticky watchdog flag
// ----------------------------------------------------------------------------
module dot_product_controller
   import dotp_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int VECTOR_WIDTH   = DEFAULT_VECTOR_WIDTH,
   parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
   parameter int ACC_WIDTH      = acc_width(DATA_WIDTH, VECTOR_WIDTH),
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   output logic                  write_en,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [DATA_WIDTH-1:0] data_a,
   output logic [DATA_WIDTH-1:0] data_b,
   output logic                  start_reading,
   input  logic                  reading_done,
   input  logic [DATA_WIDTH-1:0] mem1_output,
   input  logic [DATA_WIDTH-1:0] mem2_output,
   input  logic                  data_valid,
   input  logic [2:0]            element_count,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_result,
   output logic                  busy,
   output logic                  error
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VECTOR_WIDTH - 1);

   dotp_state_t           state;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  handshake;
   logic                  mac_clear;
   logic                  mac_enable;
   logic [ACC_WIDTH-1:0]  acc;

   // element_count is status from the wrapper that the sequencing never needs.
   logic unused_inputs;
   assign unused_inputs = ^element_count;

   // in_ready is registered and only ever high in LOAD, so it alone gates
   // acceptance of a pair.
   assign handshake = in_valid && in_ready;

   // The accumulator is cleared in KICK and only listens to the read stream
   // in ACCUM, so stray data_valid beats in other states are ignored.
   assign mac_clear  = (state == ST_KICK);
   assign mac_enable = (state == ST_ACCUM) && data_valid;

   dotp_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clear  (mac_clear),
      .enable (mac_enable),
      .a      (mem1_output),
      .b      (mem2_output),
      .acc    (acc)
   );

   // The accumulator does not move in RESULT, so it can drive the result
   // port directly and stays stable while out_ready is low.
   assign out_result = acc;

`ifdef DOTP_TIMEOUT_EN
   localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   logic [TIMER_WIDTH-1:0] timer;
   logic                   timeout_hit;

   // The timer holds the number of ACCUM cycles already completed, so this
   // fires on the TIMEOUT_CYCLES-th ACCUM cycle.
   assign timeout_hit = (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_param;
   assign unused_timeout_param = (TIMEOUT_CYCLES > 0);
   assign error = 1'b0;
`endif

   // Main sequencer. All handshake and strobe outputs are registered: each
   // is set on the edge that enters the state where it must be visible, so
   // e.g. the last write lands on the bus during FLUSH and start_reading is
   // high only during KICK, never together with write_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_LOAD;
         idx           <= '0;
         in_ready      <= 1'b1;
         busy          <= 1'b0;
         write_en      <= 1'b0;
         write_addr    <= '0;
         data_a        <= '0;
         data_b        <= '0;
         start_reading <= 1'b0;
         out_valid     <= 1'b0;
`ifdef DOTP_TIMEOUT_EN
         timer         <= '0;
         error         <= 1'b0;
`endif
      end else begin
         write_en      <= 1'b0;
         start_reading <= 1'b0;

         case (state)
            ST_LOAD: begin
               if (handshake) begin
                  write_en   <= 1'b1;
                  write_addr <= idx;
                  data_a     <= in_a;
                  data_b     <= in_b;
                  idx        <= idx + ADDR_WIDTH'(1);
                  if (idx == LAST_IDX) begin
                     state    <= ST_FLUSH;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                  end
               end
            end

            ST_FLUSH: begin
               state         <= ST_KICK;
               start_reading <= 1'b1;
            end

            ST_KICK: begin
               state <= ST_ACCUM;
`ifdef DOTP_TIMEOUT_EN
               timer <= '0;
`endif
            end

            ST_ACCUM: begin
               if (reading_done) begin
                  state     <= ST_RESULT;
                  out_valid <= 1'b1;
               end
`ifdef DOTP_TIMEOUT_EN
               else if (timeout_hit) begin
                  state    <= ST_LOAD;
                  error    <= 1'b1;
                  idx      <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  timer <= timer + TIMER_WIDTH'(1);
               end
`endif
            end

            ST_RESULT: begin
               if (out_ready) begin
                  state     <= ST_LOAD;
                  out_valid <= 1'b0;
                  idx       <= '0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end

            default: begin
               state     <= ST_LOAD;
               idx       <= '0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dot_product_controller.sv
// ----------------------------------------------------------------------------
// tb_dot_product_controller
// Directed bench for dot_product_controller with a small behavioural model
// of input_memory_wrapper (stores writes, streams them back after a kick).
// Timeout scenario is compiled only when DOTP_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_dot_product_controller;

   localparam int DATA_WIDTH   = 8;
   localparam int VECTOR_WIDTH = 4;
   localparam int ADDR_WIDTH   = 5;
   localparam int ACC_WIDTH    = 18;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_a;
   logic [DATA_WIDTH-1:0] in_b;
   logic                  write_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] data_a;
   logic [DATA_WIDTH-1:0] data_b;
   logic                  start_reading;
   logic                  reading_done = 1'b0;
   logic [DATA_WIDTH-1:0] mem1_output  = '0;
   logic [DATA_WIDTH-1:0] mem2_output  = '0;
   logic                  data_valid   = 1'b0;
   logic [2:0]            element_count;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_WIDTH-1:0]  out_result;
   logic                  busy;
   logic                  error;

   int checks_total  = 0;
   int checks_passed = 0;
   int cycle_count   = 0;

   // Wrapper model state
   logic [DATA_WIDTH-1:0] mem1 [0:31];
   logic [DATA_WIDTH-1:0] mem2 [0:31];
   int  rd_ptr        = 0;
   bit  rd_active     = 1'b0;
   bit  hang_reader   = 1'b0;
   int  write_count   = 0;
   int  kick_count    = 0;
   int  kick_cycle    = 0;
   int  overlap_count = 0;
   bit  out_valid_seen = 1'b0;
   int  addr_log [$];
   int  last_hs_cycle = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cycle_count <= cycle_count + 1;

   dot_product_controller dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_a          (in_a),
      .in_b          (in_b),
      .write_en      (write_en),
      .write_addr    (write_addr),
      .data_a        (data_a),
      .data_b        (data_b),
      .start_reading (start_reading),
      .reading_done  (reading_done),
      .mem1_output   (mem1_output),
      .mem2_output   (mem2_output),
      .data_valid    (data_valid),
      .element_count (element_count),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .busy          (busy),
      .error         (error)
   );

   // Wrapper model: captures writes, and after a start_reading pulse streams
   // one beat per cycle with reading_done on the last beat (unless hung).
   always @(negedge clk) begin
      data_valid   = 1'b0;
      reading_done = 1'b0;
      if (rst) begin
         rd_active = 1'b0;
      end else begin
         if (write_en) begin
            mem1[write_addr] = data_a;
            mem2[write_addr] = data_b;
            write_count++;
            addr_log.push_back(int'(write_addr));
         end
         if (write_en && start_reading) overlap_count++;
         if (out_valid) out_valid_seen = 1'b1;
         if (start_reading) begin
            rd_active  = 1'b1;
            rd_ptr     = 0;
            kick_count++;
            kick_cycle = cycle_count;
         end else if (rd_active) begin
            data_valid  = 1'b1;
            mem1_output = mem1[rd_ptr];
            mem2_output = mem2[rd_ptr];
            if (rd_ptr == VECTOR_WIDTH - 1) begin
               rd_active    = 1'b0;
               reading_done = !hang_reader;
            end
            rd_ptr++;
         end
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks_total++;
      assert (observed === expected) checks_passed++;
      else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
   endtask

   // Called at a negedge in LOAD; drives the four pairs (packed low byte
   // first) with `gap` idle cycles after each pair.
   task automatic apply_stimulus(input logic [31:0] av, input logic [31:0] bv,
                                 input int gap);
      check_output("in_ready_at_load", in_ready, 1);
      for (int i = 0; i < VECTOR_WIDTH; i++) begin
         in_valid      = 1'b1;
         in_a          = av[8*i +: 8];
         in_b          = bv[8*i +: 8];
         last_hs_cycle = cycle_count;
         @(negedge clk);
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic wait_result(input string tag);
      int n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_output({tag, "_out_valid"}, out_valid, 1);
   endtask

   task automatic clear_model_logs();
      write_count = 0;
      kick_count  = 0;
      addr_log.delete();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      rst           = 1'b1;
      in_valid      = 1'b0;
      in_a          = '0;
      in_b          = '0;
      out_ready     = 1'b1;
      element_count = 3'd0;
      repeat (3) @(negedge clk);

      $display("[TB] reset state");
      check_output("rst_in_ready",      in_ready,      1);
      check_output("rst_busy",          busy,          0);
      check_output("rst_write_en",      write_en,      0);
      check_output("rst_write_addr",    write_addr,    0);
      check_output("rst_start_reading", start_reading, 0);
      check_output("rst_out_valid",     out_valid,     0);
      check_output("rst_out_result",    out_result,    0);
      check_output("rst_error",         error,         0);
      rst = 1'b0;
      @(negedge clk);

      // Job 1: a={1,2,3,4}, b={5,6,7,8} -> 5+12+21+32 = 70
      $display("[TB] job 1: basic dot product");
      clear_model_logs();
      apply_stimulus({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0);
      wait_result("job1");
      check_output("job1_result",      out_result, 70);
      check_output("job1_in_ready",    in_ready,   0);
      check_output("job1_busy",        busy,       1);
      check_output("job1_kicks",       kick_count, 1);
      check_output("job1_writes",      write_count, 4);
      for (int i = 0; i < VECTOR_WIDTH; i++)
         check_output("job1_addr_order", addr_log[i], i);
      @(negedge clk);
      check_output("job1_valid_drop",  out_valid, 0);
      check_output("job1_back_ready",  in_ready,  1);
      check_output("job1_back_idle",   busy,      0);

      // Job 2: all 255 -> 4*65025 = 260100, fits in 18 bits
      $display("[TB] job 2: maximum operands");
      apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      wait_result("job2");
      check_output("job2_result", out_result, 260100);
      @(negedge clk);

      // Job 3: back-pressure on the result port, stray in_valid ignored
      $display("[TB] job 3: result hold under back-pressure");
      out_ready = 1'b0;
      apply_stimulus({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0);
      wait_result("job3");
      clear_model_logs();
      in_valid = 1'b1;
      in_a     = 8'd99;
      in_b     = 8'd99;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_output("job3_hold_valid",  out_valid,  1);
         check_output("job3_hold_result", out_result, 70);
         check_output("job3_hold_ready",  in_ready,   0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_output("job3_valid_drop", out_valid,   0);
      check_output("job3_no_write",   write_count, 0);

      // Job 4: reset in the middle of ACCUM, then replay job 1
      $display("[TB] job 4: reset mid-accumulate");
      apply_stimulus({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0);
      repeat (3) @(negedge clk);
      check_output("job4_busy_accum", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check_output("job4_rst_in_ready",  in_ready,      1);
      check_output("job4_rst_busy",      busy,          0);
      check_output("job4_rst_out_valid", out_valid,     0);
      check_output("job4_rst_result",    out_result,    0);
      check_output("job4_rst_kick",      start_reading, 0);
      check_output("job4_rst_write",     write_en,      0);
      rst = 1'b0;
      @(negedge clk);
      apply_stimulus({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0);
      wait_result("job4");
      check_output("job4_result", out_result, 70);
      @(negedge clk);

      // Job 5: gaps; a={10,20,30,40}, b={1,2,3,4} -> 10+40+90+160 = 300
      $display("[TB] job 5: gaps in the input stream");
      clear_model_logs();
      apply_stimulus({8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, 2);
      wait_result("job5");
      check_output("job5_result", out_result, 300);
      check_output("job5_writes", write_count, 4);
      for (int i = 0; i < VECTOR_WIDTH; i++)
         check_output("job5_addr_order", addr_log[i], i);
      check_output("job5_kick_latency", kick_cycle - last_hs_cycle, 2);
      @(negedge clk);

`ifdef DOTP_TIMEOUT_EN
      // Job 6: reader never reports done -> watchdog after 64 ACCUM cycles
      $display("[TB] job 6: read watchdog");
      hang_reader    = 1'b1;
      out_valid_seen = 1'b0;
      apply_stimulus({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0);
      @(negedge clk);
      check_output("job6_kick", start_reading, 1);
      repeat (64) @(negedge clk);
      check_output("job6_no_error_yet", error, 0);
      check_output("job6_still_busy",   busy,  1);
      @(negedge clk);
      check_output("job6_error",        error,          1);
      check_output("job6_back_load",    in_ready,       1);
      check_output("job6_idle",         busy,           0);
      check_output("job6_no_result",    out_valid_seen, 0);
      repeat (3) @(negedge clk);
      check_output("job6_error_sticky", error, 1);
      hang_reader = 1'b0;
`endif

      check_output("no_write_kick_overlap", overlap_count, 0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
